// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and per-boundary field layouts for pipe_skid_stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W    = 32;
  localparam int PIPE_CTRL_W    = 8;

  localparam int IF_ID_DATA_W   = 64;
  localparam int IF_ID_CTRL_W   = 1;
  localparam int ID_EX_DATA_W   = 96;
  localparam int ID_EX_CTRL_W   = 8;
  localparam int EX_MEM_DATA_W  = 64;
  localparam int EX_MEM_CTRL_W  = 4;
  localparam int MEM_WB_DATA_W  = 32;
  localparam int MEM_WB_CTRL_W  = 2;

  // IF/ID control bit
  localparam int IF_ID_BUBBLE_BIT     = 0;

  // ID/EX control bits
  localparam int ID_EX_RE_BIT         = 0;
  localparam int ID_EX_WE_BIT         = 1;
  localparam int ID_EX_USE_DST_BIT    = 2;
  localparam int ID_EX_BR_EN_BIT      = 3;
  localparam int ID_EX_BR_COND_LSB    = 4;
  localparam int ID_EX_BR_COND_W      = 3;
  localparam int ID_EX_ALU_SRC_BIT    = 7;

  // EX/MEM control bits
  localparam int EX_MEM_RE_BIT        = 0;
  localparam int EX_MEM_WE_BIT        = 1;
  localparam int EX_MEM_USE_DST_BIT   = 2;
  localparam int EX_MEM_MEM2REG_BIT   = 3;

  // MEM/WB control bits
  localparam int MEM_WB_USE_DST_BIT   = 0;
  localparam int MEM_WB_MEM2REG_BIT   = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipeline entry: valid, control and data with flush-clear of control
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_d,
  input  logic              load,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Flush squashes control so a dead entry cannot fire side effects; data is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else begin
      valid <= valid_d;
      if (load) begin
        ctrl <= ctrl_d;
        data <= data_d;
      end
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with optional 2-entry skid, flush and halt
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e state_q, state_d;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              m_load, s_load, m_from_s;
  logic              in_xfer, out_xfer;

  // With SKID the upstream ready depends only on registers, breaking the out_ready path.
  assign in_ready  = ((SKID != 0) ? !s_valid : (!m_valid || out_ready)) && !hlt && !rst;
  assign out_valid = m_valid && !hlt;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    s_load   = 1'b0;
    m_from_s = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_ONE;
          m_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_load = 1'b1;
        end else if (in_xfer && (SKID != 0)) begin
          state_d = ST_TWO;
          s_load  = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          state_d  = ST_ONE;
          m_load   = 1'b1;
          m_from_s = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; an in-flight output beat counts as delivered.
    if (flush) begin
      state_d = ST_EMPTY;
      m_load  = 1'b0;
      s_load  = 1'b0;
    end
  end

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .valid_d (state_d != ST_EMPTY),
    .load    (m_load),
    .ctrl_d  (m_from_s ? s_ctrl : in_ctrl),
    .data_d  (m_from_s ? s_data : in_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .valid_d (state_d == ST_TWO),
    .load    (s_load),
    .ctrl_d  (in_ctrl),
    .data_d  (in_data),
    .valid   (s_valid),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage (SKID=1 and SKID=0)
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hlt;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        z_in_ready, z_out_valid;
  logic [7:0]  z_out_ctrl;
  logic [31:0] z_out_data;
  logic [1:0]  z_occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut_z (
    .clk(clk), .rst(rst), .hlt(hlt), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .occupancy(z_occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b1; hlt = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_out_data", out_data, 0);

    // back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i, 8'(i));
      check($sformatf("st_rdy%0d", i), in_ready, 1);
      cyc();
      check($sformatf("st_vld%0d", i), out_valid, 1);
      check($sformatf("st_data%0d", i), out_data, i);
      check($sformatf("st_occ%0d", i), occupancy, 1);
    end
    in_valid = 1'b0;
    cyc();
    check("st_drain", out_valid, 0);

    // backpressure into skid
    out_ready = 1'b0;
    send(32'hA, 8'h1); cyc();
    check("bp_occ1", occupancy, 1);
    check("bp_rdy1", in_ready, 1);
    send(32'hB, 8'h2); cyc();
    send(32'hC, 8'h3);
    check("bp_occ2", occupancy, 2);
    check("bp_rdy0", in_ready, 0);
    check("bp_head", out_data, 32'hA);
    cyc();
    check("bp_hold_occ", occupancy, 2);
    check("bp_hold_head", out_data, 32'hA);
    out_ready = 1'b1;
    cyc();
    check("bp_out_b", out_data, 32'hB);
    check("bp_occ_b", occupancy, 1);
    check("bp_rdy_b", in_ready, 1);
    cyc();
    check("bp_out_c", out_data, 32'hC);
    check("bp_ctrl_c", out_ctrl, 8'h3);
    in_valid = 1'b0;
    cyc();
    check("bp_empty", occupancy, 0);

    // flush with a full stage and a live incoming beat
    out_ready = 1'b0;
    send(32'hD, 8'hFF); cyc();
    send(32'hE, 8'hFF); cyc();
    check("fl_pre_occ", occupancy, 2);
    check("fl_pre_ctrl", out_ctrl, 8'hFF);
    send(32'h77, 8'h55);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_data", out_data, 32'hD);
    check("fl_occ", occupancy, 0);
    cyc();
    check("fl_no_ghost", out_valid, 0);
    check("fl_no_ghost_data", out_data, 32'hD);
    check("fl_rdy", in_ready, 1);

    // halt with one entry held
    send(32'h5A, 8'h3); cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    hlt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("h_vld%0d", i), out_valid, 0);
      check($sformatf("h_rdy%0d", i), in_ready, 0);
      cyc();
      check($sformatf("h_occ%0d", i), occupancy, 1);
      check($sformatf("h_data%0d", i), out_data, 32'h5A);
    end
    hlt = 1'b0;
    #1;
    check("h_rel_vld", out_valid, 1);
    check("h_rel_data", out_data, 32'h5A);
    cyc();
    check("h_consumed", occupancy, 0);

    // reset while holding two entries
    out_ready = 1'b0;
    send(32'h11, 8'h7); cyc();
    send(32'h22, 8'h9); cyc();
    in_valid = 1'b0;
    check("mr_pre_occ", occupancy, 2);
    rst = 1'b1;
    #1;
    check("mr_vld", out_valid, 0);
    check("mr_ctrl", out_ctrl, 0);
    check("mr_data", out_data, 0);
    check("mr_occ", occupancy, 0);
    check("mr_rdy", in_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("mr_rel_rdy", in_ready, 1);

    // single-entry variant
    out_ready = 1'b0;
    send(32'h31, 8'h1);
    check("z_rdy_empty", z_in_ready, 1);
    cyc();
    check("z_occ1", z_occupancy, 1);
    check("z_rdy_full", z_in_ready, 0);
    check("z_data1", z_out_data, 32'h31);
    send(32'h32, 8'h2);
    out_ready = 1'b1;
    #1;
    check("z_rdy_pass", z_in_ready, 1);
    cyc();
    check("z_data2", z_out_data, 32'h32);
    check("z_occ_keep", z_occupancy, 1);
    check("z_vld2", z_out_valid, 1);
    in_valid = 1'b0;
    cyc();
    check("z_empty", z_occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
